wb_regfile: RTL and testbench

Write-back stage and architectural register file for the 32-bit pipeline. Consumes the registered outputs of the DM/WB stage buffer, selects the memory-load or ALU result, commits it to a 32×32 register file, and serves two combinational read ports to the decode stage with same-cycle write-to-read bypass. Also keeps a retired-write counter for performance and debug.

---
 rtl/mips_pkg.sv | 16 +
 rtl/wb_regfile_if.sv | 33 +++
 rtl/regfile_read_port.sv | 24 ++
 rtl/wb_regfile.sv | 108 ++++++++++
 tb/tb_wb_regfile.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared pipeline constants: register-file geometry and write-back mux encodings.
package mips_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned NREGS      = 32;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   localparam reg_addr_t REG_ZERO = 5'd0;

   // Write-back result select, shared with the control unit.
   localparam logic WB_SEL_MEM = 1'b1;
   localparam logic WB_SEL_ALU = 1'b0;

endpackage

// File: rtl/wb_regfile_if.sv
// DM/WB write-back request plus the two decode-stage read ports.
interface wb_regfile_if #(
   parameter int unsigned DATA_W = 32
) ();
   import mips_pkg::*;

   logic [DATA_W-1:0] wb_dm_out;
   logic [DATA_W-1:0] wb_dm_alu_out;
   reg_addr_t         wb_dm_rd_out_addr;
   logic              wb_dm_w_enable;
   logic              wb_dm_wb_mux_ctrl;

   reg_addr_t         rs1_addr;
   reg_addr_t         rs2_addr;
   logic [DATA_W-1:0] rs1_data;
   logic [DATA_W-1:0] rs2_data;

   logic [DATA_W-1:0] wb_data;
   logic              wb_commit;

   modport master (
      output wb_dm_out, wb_dm_alu_out, wb_dm_rd_out_addr, wb_dm_w_enable,
             wb_dm_wb_mux_ctrl, rs1_addr, rs2_addr,
      input  rs1_data, rs2_data, wb_data, wb_commit
   );

   modport slave (
      input  wb_dm_out, wb_dm_alu_out, wb_dm_rd_out_addr, wb_dm_w_enable,
             wb_dm_wb_mux_ctrl, rs1_addr, rs2_addr,
      output rs1_data, rs2_data, wb_data, wb_commit
   );

endinterface

// File: rtl/regfile_read_port.sv
// One register-file read port: x0 forced to zero, optional same-cycle bypass.
module regfile_read_port #(
   parameter int unsigned DATA_W = 32
) (
   input  mips_pkg::reg_addr_t rd_addr,
   input  logic [DATA_W-1:0]   stored_data,
   input  mips_pkg::reg_addr_t byp_addr,
   input  logic [DATA_W-1:0]   byp_data,
   input  logic                byp_commit,
   output logic [DATA_W-1:0]   rd_data
);
   import mips_pkg::*;

   // x0 wins over bypass, bypass wins over stored contents
   always_comb begin
      rd_data = stored_data;
      if (rd_addr == REG_ZERO) begin
         rd_data = '0;
      end else if (byp_commit && (rd_addr == byp_addr)) begin
         rd_data = byp_data;
      end
   end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: result select, 31x XLEN register file, read ports, retired-write counter.
module wb_regfile #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32,
   parameter int unsigned CNT_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   wb_regfile_if.slave         bus,
   output logic [CNT_W-1:0]    retired_cnt,
   input  mips_pkg::reg_addr_t dbg_addr,
   output logic [XLEN-1:0]     dbg_data
);
   import mips_pkg::*;

   // x0 has no storage
   logic [XLEN-1:0]  regs_q [1:NREGS-1];
   logic [XLEN-1:0]  regs_d [1:NREGS-1];
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   logic [XLEN-1:0]  wb_data;
   logic             wb_commit;
   logic             byp_commit;
   logic [XLEN-1:0]  rs1_stored;
   logic [XLEN-1:0]  rs2_stored;
   logic [XLEN-1:0]  dbg_stored;

   // result select and commit qualification
   always_comb begin
      wb_data = bus.wb_dm_alu_out;
      case (bus.wb_dm_wb_mux_ctrl)
         WB_SEL_MEM: wb_data = bus.wb_dm_out;
         WB_SEL_ALU: wb_data = bus.wb_dm_alu_out;
         default:    wb_data = bus.wb_dm_alu_out;
      endcase
      wb_commit  = bus.wb_dm_w_enable && (bus.wb_dm_rd_out_addr != REG_ZERO);
      // bypass is suppressed during reset so every read port reads zero
      byp_commit = wb_commit && rst_n;
   end

   assign bus.wb_data   = wb_data;
   assign bus.wb_commit = wb_commit;

   // next-state for storage and counter; only a commit touches state
   always_comb begin
      regs_d = regs_q;
      cnt_d  = cnt_q;
      if (wb_commit) begin
         regs_d[bus.wb_dm_rd_out_addr] = wb_data;
         cnt_d                         = cnt_q + CNT_W'(1);
      end
   end

   // storage and counter registers, asynchronously cleared
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 1; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
         cnt_q <= '0;
      end else begin
         regs_q <= regs_d;
         cnt_q  <= cnt_d;
      end
   end

   assign retired_cnt = cnt_q;

   // stored-array lookups, x0 guarded before indexing
   always_comb begin
      rs1_stored = '0;
      rs2_stored = '0;
      dbg_stored = '0;
      if (bus.rs1_addr != REG_ZERO) rs1_stored = regs_q[bus.rs1_addr];
      if (bus.rs2_addr != REG_ZERO) rs2_stored = regs_q[bus.rs2_addr];
      if (dbg_addr     != REG_ZERO) dbg_stored = regs_q[dbg_addr];
   end

   regfile_read_port #(.DATA_W(XLEN)) u_rs1_port (
      .rd_addr     (bus.rs1_addr),
      .stored_data (rs1_stored),
      .byp_addr    (bus.wb_dm_rd_out_addr),
      .byp_data    (wb_data),
      .byp_commit  (byp_commit),
      .rd_data     (bus.rs1_data)
   );

   regfile_read_port #(.DATA_W(XLEN)) u_rs2_port (
      .rd_addr     (bus.rs2_addr),
      .stored_data (rs2_stored),
      .byp_addr    (bus.wb_dm_rd_out_addr),
      .byp_data    (wb_data),
      .byp_commit  (byp_commit),
      .rd_data     (bus.rs2_data)
   );

   // debug port shows stored contents only
   regfile_read_port #(.DATA_W(XLEN)) u_dbg_port (
      .rd_addr     (dbg_addr),
      .stored_data (dbg_stored),
      .byp_addr    (REG_ZERO),
      .byp_data    ('0),
      .byp_commit  (1'b0),
      .rd_data     (dbg_data)
   );

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile (default instance plus a 4-bit counter instance).
module tb_wb_regfile;
   import mips_pkg::*;

   logic clk;
   logic rst_n;

   wb_regfile_if #(.DATA_W(32)) bus_a ();
   wb_regfile_if #(.DATA_W(32)) bus_b ();

   logic [31:0] retired_a;
   logic [3:0]  retired_b;
   reg_addr_t   dbg_addr_a;
   reg_addr_t   dbg_addr_b;
   logic [31:0] dbg_data_a;
   logic [31:0] dbg_data_b;

   int unsigned n_checks;
   int unsigned n_errors;

   wb_regfile #(.XLEN(32), .NREGS(32), .CNT_W(32)) dut_a (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus_a),
      .retired_cnt (retired_a),
      .dbg_addr    (dbg_addr_a),
      .dbg_data    (dbg_data_a)
   );

   wb_regfile #(.XLEN(32), .NREGS(32), .CNT_W(4)) dut_b (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus_b),
      .retired_cnt (retired_b),
      .dbg_addr    (dbg_addr_b),
      .dbg_data    (dbg_data_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic drive_wb(input logic en, input logic [4:0] rd, input logic [31:0] alu,
                           input logic [31:0] dm, input logic sel);
      bus_a.wb_dm_w_enable    = en;
      bus_a.wb_dm_rd_out_addr = rd;
      bus_a.wb_dm_alu_out     = alu;
      bus_a.wb_dm_out         = dm;
      bus_a.wb_dm_wb_mux_ctrl = sel;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      drive_wb(1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
      bus_a.rs1_addr = 5'd5;
      bus_a.rs2_addr = 5'd0;
      dbg_addr_a     = 5'd0;
      bus_b.wb_dm_w_enable    = 1'b0;
      bus_b.wb_dm_rd_out_addr = 5'd0;
      bus_b.wb_dm_alu_out     = 32'h0;
      bus_b.wb_dm_out         = 32'h0;
      bus_b.wb_dm_wb_mux_ctrl = 1'b0;
      bus_b.rs1_addr          = 5'd0;
      bus_b.rs2_addr          = 5'd0;
      dbg_addr_b              = 5'd0;
      #12;
      check("reset_rs1_x5", bus_a.rs1_data, 32'h0);
      check("reset_cnt", retired_a, 32'h0);
      check("reset_cnt_b", {28'h0, retired_b}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();

      // result select: ALU then memory into x3
      drive_wb(1'b1, 5'd3, 32'h11, 32'h22, WB_SEL_ALU);
      dbg_addr_a = 5'd3;
      #1;
      check("mux_alu_wb_data", bus_a.wb_data, 32'h11);
      check("mux_alu_commit", {31'h0, bus_a.wb_commit}, 32'h1);
      next_cycle();
      check("mux_alu_x3", dbg_data_a, 32'h11);
      drive_wb(1'b1, 5'd3, 32'h11, 32'h22, WB_SEL_MEM);
      #1;
      check("mux_mem_wb_data", bus_a.wb_data, 32'h22);
      next_cycle();
      check("mux_mem_x3", dbg_data_a, 32'h22);
      check("mux_cnt", retired_a, 32'd2);

      // x0 protection
      drive_wb(1'b1, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, WB_SEL_ALU);
      bus_a.rs1_addr = 5'd0;
      bus_a.rs2_addr = 5'd0;
      dbg_addr_a     = 5'd0;
      #1;
      check("x0_commit", {31'h0, bus_a.wb_commit}, 32'h0);
      check("x0_rs1", bus_a.rs1_data, 32'h0);
      check("x0_rs2", bus_a.rs2_data, 32'h0);
      next_cycle();
      check("x0_dbg", dbg_data_a, 32'h0);
      check("x0_cnt", retired_a, 32'd2);

      // bypass on both ports, debug port unbypassed
      drive_wb(1'b1, 5'd7, 32'h1, 32'h0, WB_SEL_ALU);
      next_cycle();
      drive_wb(1'b1, 5'd7, 32'h99, 32'h0, WB_SEL_ALU);
      bus_a.rs1_addr = 5'd7;
      bus_a.rs2_addr = 5'd7;
      dbg_addr_a     = 5'd7;
      #1;
      check("byp_rs1", bus_a.rs1_data, 32'h99);
      check("byp_rs2", bus_a.rs2_data, 32'h99);
      check("byp_dbg_old", dbg_data_a, 32'h1);
      next_cycle();
      drive_wb(1'b0, 5'd7, 32'h0, 32'h0, WB_SEL_ALU);
      #1;
      check("byp_dbg_new", dbg_data_a, 32'h99);
      check("byp_rs1_stored", bus_a.rs1_data, 32'h99);
      check("byp_cnt", retired_a, 32'd4);

      // disabled write leaves x9 alone and does not bypass
      drive_wb(1'b1, 5'd9, 32'h55, 32'h0, WB_SEL_ALU);
      next_cycle();
      drive_wb(1'b0, 5'd9, 32'hABCD, 32'hABCD, WB_SEL_ALU);
      bus_a.rs1_addr = 5'd9;
      dbg_addr_a     = 5'd9;
      #1;
      check("dis_commit", {31'h0, bus_a.wb_commit}, 32'h0);
      check("dis_rs1", bus_a.rs1_data, 32'h55);
      next_cycle();
      check("dis_x9", dbg_data_a, 32'h55);
      check("dis_cnt", retired_a, 32'd5);
      drive_wb(1'b0, 5'd9, 32'hxxxx_xxxx, 32'hxxxx_xxxx, 1'bx);
      next_cycle();
      check("dis_x_data", dbg_data_a, 32'h55);

      // asynchronous reset mid-cycle, then reset holding through a commit edge
      drive_wb(1'b1, 5'd5, 32'hDEAD_BEEF, 32'h0, WB_SEL_ALU);
      next_cycle();
      drive_wb(1'b0, 5'd0, 32'h0, 32'h0, WB_SEL_ALU);
      bus_a.rs1_addr = 5'd5;
      dbg_addr_a     = 5'd5;
      #1;
      check("pre_rst_x5", bus_a.rs1_data, 32'hDEAD_BEEF);
      check("pre_rst_cnt", retired_a, 32'd6);
      rst_n = 1'b0;
      #1;
      check("rst_rs1_x5", bus_a.rs1_data, 32'h0);
      check("rst_cnt", retired_a, 32'h0);
      drive_wb(1'b1, 5'd5, 32'h1234, 32'h0, WB_SEL_ALU);
      #1;
      check("rst_wb_data", bus_a.wb_data, 32'h1234);
      check("rst_rs1_nobyp", bus_a.rs1_data, 32'h0);
      next_cycle();
      check("rst_edge_x5", dbg_data_a, 32'h0);
      check("rst_edge_cnt", retired_a, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();
      check("post_rst_x5", dbg_data_a, 32'h1234);
      check("post_rst_cnt", retired_a, 32'd1);
      drive_wb(1'b0, 5'd0, 32'h0, 32'h0, WB_SEL_ALU);

      // 4-bit counter wraps after 16 commits
      for (int i = 0; i < 17; i++) begin
         bus_b.wb_dm_w_enable    = 1'b1;
         bus_b.wb_dm_rd_out_addr = 5'(1 + i);
         bus_b.wb_dm_alu_out     = 32'(i);
         next_cycle();
         if (i == 14) check("wrap_cnt_15", {28'h0, retired_b}, 32'd15);
      end
      bus_b.wb_dm_w_enable = 1'b0;
      dbg_addr_b = 5'd17;
      #1;
      check("wrap_cnt_17", {28'h0, retired_b}, 32'd1);
      check("wrap_x17", dbg_data_b, 32'd16);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
